// File: rtl/rdq_pkg.sv
// Shared types and helpers for the rename-to-dispatch queue.
// Entry layout, pointer/count widths and lane compaction offsets.
package rdq_pkg;

  localparam int RENAME_WIDTH       = 2;
  localparam int PRF_INT_INDEX_SIZE = 7;
  localparam int RDQ_DEPTH          = 16;
  localparam int RDQ_PAYLOAD_W      = 64;
  localparam int RDQ_PTR_W          = $clog2(RDQ_DEPTH);
  localparam int RDQ_CNT_W          = $clog2(RDQ_DEPTH) + 1;
  localparam int RDQ_OFF_W          = $clog2(RENAME_WIDTH + 1);

  typedef logic [PRF_INT_INDEX_SIZE-1:0] preg_t;

  typedef struct packed {
    preg_t                    prs1;
    preg_t                    prs2;
    preg_t                    prd;
    preg_t                    prev_rd;
    logic                     prev_rd_valid;
    logic [RDQ_PAYLOAD_W-1:0] payload;
  } rdq_entry_t;

  typedef logic [RENAME_WIDTH-1:0][RDQ_OFF_W-1:0] lane_off_t;

  // Exclusive prefix sum: slot offset of each lane relative to tail.
  function automatic lane_off_t lane_compact_offsets(input logic [RENAME_WIDTH-1:0] valid);
    lane_off_t            off;
    logic [RDQ_OFF_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < RENAME_WIDTH; i++) begin
      off[i] = acc;
      acc    = acc + RDQ_OFF_W'(valid[i]);
    end
    return off;
  endfunction

endpackage

// File: rtl/rdq_prefix_count.sv
// Popcount (LEADING=0) or leading-ones run length from bit 0 (LEADING=1).
// Latency: combinational. Backpressure: none.
// Used for enqueue lane count and in-order dispatch count.
module rdq_prefix_count #(
  parameter int W       = 2,
  parameter bit LEADING = 1'b0
) (
  input  logic [W-1:0]           vec,
  output logic [$clog2(W+1)-1:0] cnt
);

  localparam int CW = $clog2(W + 1);

  logic run;

  always_comb begin
    cnt = '0;
    run = 1'b1;
    for (int i = 0; i < W; i++) begin
      run = run & vec[i];
      if (LEADING ? run : vec[i]) cnt = cnt + CW'(1);
    end
  end

endmodule

// File: rtl/rename_dispatch_queue.sv
// In-order circular buffer from rename to dispatch; sparse input lanes are compacted.
// Latency: 1 cycle push-to-dispatch. Backpressure: stall_out when free slots < IN_WIDTH.
// Dispatch pops only the leading prefix of valid&ready lanes; recover flushes everything.
module rename_dispatch_queue
  import rdq_pkg::*;
#(
  parameter int DEPTH         = RDQ_DEPTH,
  parameter int IN_WIDTH      = RENAME_WIDTH,
  parameter int OUT_WIDTH     = 2,
  parameter int PAYLOAD_WIDTH = RDQ_PAYLOAD_W
) (
  input  logic                                         clock,
  input  logic                                         reset,
  input  logic                                         recover,
  input  logic [IN_WIDTH-1:0]                          in_valid,
  input  logic [IN_WIDTH-1:0][PRF_INT_INDEX_SIZE-1:0]  in_prs1,
  input  logic [IN_WIDTH-1:0][PRF_INT_INDEX_SIZE-1:0]  in_prs2,
  input  logic [IN_WIDTH-1:0][PRF_INT_INDEX_SIZE-1:0]  in_prd,
  input  logic [IN_WIDTH-1:0][PRF_INT_INDEX_SIZE-1:0]  in_prev_rd,
  input  logic [IN_WIDTH-1:0]                          in_prev_rd_valid,
  input  logic [IN_WIDTH-1:0][PAYLOAD_WIDTH-1:0]       in_payload,
  output logic                                         stall_out,
  output logic [OUT_WIDTH-1:0]                         out_valid,
  output rdq_entry_t [OUT_WIDTH-1:0]                   out_entry,
  input  logic [OUT_WIDTH-1:0]                         out_ready,
  output logic [$clog2(DEPTH):0]                       count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int PIN_W = $clog2(IN_WIDTH + 1);
  localparam int POUT_W = $clog2(OUT_WIDTH + 1);

  logic [PTR_W-1:0]     head_q;
  logic [PTR_W-1:0]     tail_q;
  logic [CNT_W-1:0]     count_q;
  rdq_entry_t           mem [DEPTH];

  logic [PIN_W-1:0]     n_push;
  logic [PIN_W-1:0]     n_push_eff;
  logic [POUT_W-1:0]    n_pop;
  logic                 push_en;
  lane_off_t            off;
  logic [OUT_WIDTH-1:0] fire_vec;
  rdq_entry_t           in_entry [IN_WIDTH];

  // Conservative: based on registered occupancy, ignores same-cycle pops.
  assign stall_out  = (CNT_W'(DEPTH) - count_q) < CNT_W'(IN_WIDTH);
  assign push_en    = !stall_out && !recover;
  assign n_push_eff = push_en ? n_push : '0;
  assign off        = lane_compact_offsets(in_valid);
  assign fire_vec   = out_valid & out_ready;
  assign count      = count_q;

  always_comb begin
    for (int i = 0; i < IN_WIDTH; i++) begin
      in_entry[i].prs1          = in_prs1[i];
      in_entry[i].prs2          = in_prs2[i];
      in_entry[i].prd           = in_prd[i];
      in_entry[i].prev_rd       = in_prev_rd[i];
      in_entry[i].prev_rd_valid = in_prev_rd_valid[i];
      in_entry[i].payload       = in_payload[i];
    end
  end

  always_comb begin
    for (int k = 0; k < OUT_WIDTH; k++) begin
      out_valid[k] = count_q > CNT_W'(k);
      out_entry[k] = mem[head_q + PTR_W'(k)];
    end
  end

  rdq_prefix_count #(.W(IN_WIDTH), .LEADING(1'b0)) u_push_cnt (
    .vec (in_valid),
    .cnt (n_push)
  );

  rdq_prefix_count #(.W(OUT_WIDTH), .LEADING(1'b1)) u_pop_cnt (
    .vec (fire_vec),
    .cnt (n_pop)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (recover) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      tail_q  <= tail_q + PTR_W'(n_push_eff);
      head_q  <= head_q + PTR_W'(n_pop);
      count_q <= count_q + CNT_W'(n_push_eff) - CNT_W'(n_pop);
    end
  end

  // Array needs no reset: occupancy is tracked solely by count_q.
  always_ff @(posedge clock) begin
    if (push_en) begin
      for (int i = 0; i < IN_WIDTH; i++) begin
        if (in_valid[i]) mem[tail_q + PTR_W'(off[i])] <= in_entry[i];
      end
    end
  end

  a_occupancy: assert property (@(posedge clock) disable iff (!reset)
    (count_q <= CNT_W'(DEPTH)) && (CNT_W'(n_pop) <= count_q));

endmodule

// File: tb/tb_rename_dispatch_queue.sv
// Directed bench for rename_dispatch_queue with a scoreboard of expected dispatch order.
module tb_rename_dispatch_queue;
  import rdq_pkg::*;

  localparam int DEPTH = 16;

  logic                                   clock;
  logic                                   reset;
  logic                                   recover;
  logic [1:0]                             in_valid;
  logic [1:0][PRF_INT_INDEX_SIZE-1:0]     in_prs1;
  logic [1:0][PRF_INT_INDEX_SIZE-1:0]     in_prs2;
  logic [1:0][PRF_INT_INDEX_SIZE-1:0]     in_prd;
  logic [1:0][PRF_INT_INDEX_SIZE-1:0]     in_prev_rd;
  logic [1:0]                             in_prev_rd_valid;
  logic [1:0][RDQ_PAYLOAD_W-1:0]          in_payload;
  logic                                   stall_out;
  logic [1:0]                             out_valid;
  rdq_entry_t [1:0]                       out_entry;
  logic [1:0]                             out_ready;
  logic [4:0]                             count;

  rdq_entry_t exp_q[$];
  int         mdl_count;
  int         tag;
  int         checks;
  int         errors;

  rename_dispatch_queue dut (
    .clock            (clock),
    .reset            (reset),
    .recover          (recover),
    .in_valid         (in_valid),
    .in_prs1          (in_prs1),
    .in_prs2          (in_prs2),
    .in_prd           (in_prd),
    .in_prev_rd       (in_prev_rd),
    .in_prev_rd_valid (in_prev_rd_valid),
    .in_payload       (in_payload),
    .stall_out        (stall_out),
    .out_valid        (out_valid),
    .out_entry        (out_entry),
    .out_ready        (out_ready),
    .count            (count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic rdq_entry_t mk(input int prd, input int t);
    rdq_entry_t e;
    e.prd           = PRF_INT_INDEX_SIZE'(prd);
    e.prs1          = PRF_INT_INDEX_SIZE'(prd + 1);
    e.prs2          = PRF_INT_INDEX_SIZE'(prd + 2);
    e.prev_rd       = PRF_INT_INDEX_SIZE'(prd + 3);
    e.prev_rd_valid = prd[0];
    e.payload       = {32'hA5A5_0000, 32'(t)};
    return e;
  endfunction

  // One cycle of stimulus; the model decides acceptance and pop count.
  task automatic step(input logic [1:0] v, input int p0, input int p1,
                      input logic [1:0] rdy, input logic rec);
    rdq_entry_t e [2];
    int np;
    bit f0, f1;
    e[0] = mk(p0, tag);
    e[1] = mk(p1, tag + 1);
    tag += 2;
    for (int i = 0; i < 2; i++) begin
      in_prs1[i]          = e[i].prs1;
      in_prs2[i]          = e[i].prs2;
      in_prd[i]           = e[i].prd;
      in_prev_rd[i]       = e[i].prev_rd;
      in_prev_rd_valid[i] = e[i].prev_rd_valid;
      in_payload[i]       = e[i].payload;
    end
    in_valid  = v;
    out_ready = rdy;
    recover   = rec;
    np = 0;
    if (!rec && (DEPTH - mdl_count) >= 2) begin
      for (int i = 0; i < 2; i++) begin
        if (v[i]) begin
          exp_q.push_back(e[i]);
          np++;
        end
      end
    end
    f0 = !rec && (mdl_count > 0) && rdy[0];
    f1 = f0 && (mdl_count > 1) && rdy[1];
    @(posedge clock);
    #1;
    if (rec) begin
      mdl_count = 0;
      exp_q.delete();
    end else begin
      mdl_count = mdl_count + np - int'(f0) - int'(f1);
    end
    in_valid  = '0;
    out_ready = '0;
    recover   = 1'b0;
  endtask

  // Monitor: status each cycle, and every dispatched entry against the scoreboard.
  always @(negedge clock) begin
    logic [1:0] ev;
    bit         run;
    rdq_entry_t exp_e;
    ev = {mdl_count > 1, mdl_count > 0};
    chk("count", 128'(count), 128'(mdl_count));
    chk("out_valid", 128'(out_valid), 128'(ev));
    chk("stall_out", 128'(stall_out), 128'((DEPTH - mdl_count) < 2));
    if (reset && !recover) begin
      run = 1'b1;
      for (int k = 0; k < 2; k++) begin
        run = run && ev[k] && out_ready[k];
        if (run) begin
          if (exp_q.size() == 0) begin
            chk("sb_underflow", 128'(k), 128'(99));
          end else begin
            exp_e = exp_q.pop_front();
            chk($sformatf("dispatch_lane%0d", k), 128'(out_entry[k]), 128'(exp_e));
          end
        end
      end
    end
  end

  initial begin
    checks = 0; errors = 0; tag = 0; mdl_count = 0;
    reset = 1'b0; recover = 1'b0; in_valid = '0; out_ready = '0;
    in_prs1 = '0; in_prs2 = '0; in_prd = '0; in_prev_rd = '0;
    in_prev_rd_valid = '0; in_payload = '0;
    #12 reset = 1'b1;
    @(posedge clock); #1;

    // Idle after reset
    repeat (2) step(2'b00, 0, 0, 2'b00, 1'b0);

    // Sparse push on lane 1 only lands in slot 0
    step(2'b10, 0, 7, 2'b00, 1'b0);

    // Fill to 15, then stalled pushes must be dropped
    for (int i = 0; i < 7; i++) step(2'b11, 20 + 2*i, 21 + 2*i, 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) step(2'b11, 50 + 2*i, 51 + 2*i, 2'b00, 1'b0);
    repeat (8) step(2'b00, 0, 0, 2'b11, 1'b0);

    // Non-prefix ready takes nothing; full ready takes two
    step(2'b11, 30, 31, 2'b00, 1'b0);
    step(2'b01, 32, 0, 2'b00, 1'b0);
    step(2'b00, 0, 0, 2'b10, 1'b0);
    step(2'b00, 0, 0, 2'b11, 1'b0);
    step(2'b00, 0, 0, 2'b01, 1'b0);

    // Move head/tail to 14 (currently at 2)
    for (int i = 0; i < 6; i++) step(2'b11, 60 + 2*i, 61 + 2*i, 2'b11, 1'b0);
    step(2'b00, 0, 0, 2'b11, 1'b0);

    // Wrap-around across index 15 -> 0
    step(2'b11, 1, 2, 2'b11, 1'b0);
    step(2'b11, 3, 4, 2'b11, 1'b0);
    step(2'b00, 0, 0, 2'b11, 1'b0);

    // Recover with count=6, inputs and ready active
    for (int i = 0; i < 3; i++) step(2'b11, 80 + 2*i, 81 + 2*i, 2'b00, 1'b0);
    step(2'b11, 90, 91, 2'b11, 1'b1);
    step(2'b00, 0, 0, 2'b00, 1'b0);
    step(2'b01, 5, 0, 2'b00, 1'b0);
    step(2'b00, 0, 0, 2'b01, 1'b0);

    // Asynchronous reset mid-run with count=5
    step(2'b11, 100, 101, 2'b00, 1'b0);
    step(2'b11, 102, 103, 2'b00, 1'b0);
    step(2'b01, 104, 0, 2'b00, 1'b0);
    #2;
    reset = 1'b0;
    mdl_count = 0;
    exp_q.delete();
    #1;
    chk("async_reset_count", 128'(count), 128'(0));
    chk("async_reset_valid", 128'(out_valid), 128'(0));
    @(posedge clock); #3;
    reset = 1'b1;
    @(posedge clock); #1;
    step(2'b01, 9, 0, 2'b00, 1'b0);
    step(2'b00, 0, 0, 2'b01, 1'b0);

    @(negedge clock); #1;
    chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rename_dispatch_queue.md
Name: rename_dispatch_queue

Overview:
In-order circular buffer between the rename stage (mapping table outputs) and the issue-queue dispatch logic. Each cycle it accepts up to IN_WIDTH renamed micro-ops and compacts sparse lanes into consecutive entries. Each cycle it presents up to OUT_WIDTH oldest entries to dispatch under a prefix valid/ready handshake. It drives back-pressure to rename when it cannot guarantee space, and flushes completely on recover.

Parameters:
DEPTH, 16, number of entries; power of two, at least 2*IN_WIDTH
IN_WIDTH, `RENAME_WIDTH, rename lanes accepted per cycle
OUT_WIDTH, 2, dispatch lanes presented per cycle
PAYLOAD_WIDTH, 64, opaque decoded-uop bits (opcode, imm, pc, ...) carried unchanged

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
recover  in  1  mispredict flush; empties the queue
in_valid  in  IN_WIDTH  per-lane uop present; any pattern, may be sparse
in_prs1  in  IN_WIDTH x `PRF_INT_INDEX_SIZE  renamed source 1
in_prs2  in  IN_WIDTH x `PRF_INT_INDEX_SIZE  renamed source 2
in_prd  in  IN_WIDTH x `PRF_INT_INDEX_SIZE  renamed destination
in_prev_rd  in  IN_WIDTH x `PRF_INT_INDEX_SIZE  previous mapping of rd
in_prev_rd_valid  in  IN_WIDTH  prev_rd must be freed at commit
in_payload  in  IN_WIDTH x PAYLOAD_WIDTH  opaque uop data
stall_out  out  1  back-pressure to rename and mapping table
out_valid  out  OUT_WIDTH  lane k holds the (k+1)-th oldest entry
out_entry  out  OUT_WIDTH x rdq_entry_t  entry fields for dispatch
out_ready  in  OUT_WIDTH  dispatch accepts lane k
count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- State: head and tail pointers (log2 DEPTH bits, wrap modulo DEPTH), count register, and an entry array. No per-entry valid bits are needed; occupancy is derived from count.
- Reset (reset=0, async): head=0, tail=0, count=0. Entry array contents are don't-care. Outputs after reset: out_valid=0, stall_out=0, count=0.
- stall_out = (DEPTH - count) < IN_WIDTH.
  - Computed from the registered count only; it is conservative and ignores same-cycle pops.
  - It is combinational from state, so there is no path from in_valid.
- Push, when !stall_out && !recover:
  - n_push = popcount(in_valid).
  - Valid lanes are written in ascending lane order at tail, tail+1, ... with no gaps.
  - tail += n_push.
  - When stall_out=1, inputs are ignored; rename holds them.
- Pop:
  - out_valid[k] = (count > k).
  - out_entry[k] = array[head+k mod DEPTH].
  - n_pop = length of the leading run of (out_valid & out_ready) starting at lane 0. A ready on lane k counts only if lanes 0..k-1 also fire. Non-prefix ready patterns are legal, but only the prefix is taken.
  - head += n_pop.
- Simultaneous push and pop: count_next = count + n_push - n_pop.
  - A pushed entry is never visible on out_* in the same cycle; push-to-dispatch latency is 1 cycle minimum.
  - Full then pop: the freed space affects stall_out only in the next cycle.
- recover=1 (dominates push and pop): next edge sets head=0, tail=0, count=0. All in_* that cycle are dropped, and no entry counts as dispatched, even if out_ready was high.
- Wrap-around: a push or read window crossing index DEPTH-1 continues at index 0; entries remain in program order.
- Reset asserted mid-operation: the queue empties immediately (async), regardless of clock.
- Invariant, checked by assertion: 0 <= count <= DEPTH; n_pop <= count.

Decomposition:
- Package rdq_pkg (or the shared micro_op.svh) holds:
  - rdq_entry_t: packed struct {prs1, prs2, prd, prev_rd, prev_rd_valid, payload}.
  - Function lane_compact_offsets(in_valid) returning the prefix-sum slot offsets.
  - Localparams RDQ_PTR_W and RDQ_CNT_W.
- One natural sub-module: rdq_prefix_count, a generic leading-ones / popcount unit. It is instantiated twice, for n_push (popcount of in_valid) and n_pop (leading run of out_valid & out_ready).

Test Plan:
- Reset, then idle: count=0, out_valid=00, stall_out=0. Assert reset low mid-run with count=5: count reads 0 immediately, before any clock edge.
- Sparse push: in_valid=10 with prd=7 on lane 1 -> next cycle count=1, out_valid=01, out_entry[0].prd=7 (compacted into slot 0).
- Fill: DEPTH=16, IN_WIDTH=2, push 2/cycle with out_ready=00 -> stall_out rises when count=15. With in_valid=11 held, count stays 15 and no entry is overwritten.
- Non-prefix ready: count=3, out_ready=10 -> n_pop=0, count unchanged. Then out_ready=11 -> n_pop=2, count=1, and the oldest remaining entry appears on lane 0.
- Wrap-around: head=14, tail=14; push 4 entries with prd=1,2,3,4, popping 2/cycle concurrently -> dispatch order is 1,2,3,4 across indices 14,15,0,1.
- Recover with count=6, in_valid=11, out_ready=11: next cycle count=0, out_valid=00, head=tail=0, and none of the 2 lane inputs is enqueued.
